// File: rtl/pipo_share_arbiter.sv
// Round-robin arbiter sharing one parallel-in/parallel-out register.
// Each grant loads the winner's word, then freezes it for HOLD_CYCLES.
module pipo_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [IW-1:0]          q_owner,
  output logic                   busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              valid_q, valid_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic              found;
  logic [IW-1:0]     win;

  // Search ptr, ptr+1, ... with an explicit wrap back to 0.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    valid_d = valid_q;
    owner_d = owner_q;
    gnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          q_d     = '0;
          valid_d = 1'b0;
        end else if (found) begin
          q_d     = req_data[int'(win)*WIDTH +: WIDTH];
          valid_d = 1'b1;
          owner_d = win;
          gnt_d   = '0;
          gnt_d[win] = 1'b1;
          ptr_d   = (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
          cnt_d   = CW'(HOLD_CYCLES-1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
        if (clr) begin
          q_d     = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = valid_q;
  assign q_owner = owner_q;
  assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Directed bench for pipo_share_arbiter (N_REQ=4, WIDTH=4, HOLD=2).
// Outputs are sampled 1ns after each rising edge.
module tb_pipo_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        clr;
  logic [3:0]  gnt;
  logic [3:0]  q;
  logic        q_valid;
  logic [1:0]  q_owner;
  logic        busy;

  int tests;
  int failed;

  pipo_share_arbiter #(
    .N_REQ(4),
    .WIDTH(4),
    .HOLD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .clr(clr),
    .gnt(gnt),
    .q(q),
    .q_valid(q_valid),
    .q_owner(q_owner),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt,
                         input logic [3:0] e_q, input logic e_v,
                         input logic [1:0] e_own, input logic e_busy);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".q"}, 32'(q), 32'(e_q));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(e_v));
    chk({tag, ".q_owner"}, 32'(q_owner), 32'(e_own));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  initial begin
    logic [3:0] oh;
    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    clr      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);

    req      = 4'b0100;
    req_data = 16'h0A00;
    tick();
    chk_out("first_grant", 4'b0100, 4'hA, 1'b1, 2'd2, 1'b1);

    req      = 4'b0001;
    req_data = 16'hFFFF;
    tick();
    chk_out("freeze1", 4'b0000, 4'hA, 1'b1, 2'd2, 1'b1);
    tick();
    chk_out("freeze2", 4'b0000, 4'hA, 1'b1, 2'd2, 1'b0);
    tick();
    chk_out("freeze_grant", 4'b0001, 4'hF, 1'b1, 2'd0, 1'b1);
    req = '0;
    tick();
    tick();
    chk_out("idle_a", 4'b0000, 4'hF, 1'b1, 2'd0, 1'b0);

    req      = 4'b1000;
    req_data = 16'h4321;
    tick();
    chk_out("wrap_g3", 4'b1000, 4'h4, 1'b1, 2'd3, 1'b1);
    req = 4'b1010;
    tick();
    tick();
    chk_out("wrap_idle", 4'b0000, 4'h4, 1'b1, 2'd3, 1'b0);
    tick();
    chk_out("wrap_g1", 4'b0010, 4'h2, 1'b1, 2'd1, 1'b1);
    tick();
    tick();
    tick();
    chk_out("wrap_g3b", 4'b1000, 4'h4, 1'b1, 2'd3, 1'b1);

    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d_hold", i), 4'b0000,
              (i == 0) ? 4'h4 : 4'((i - 1) % 4 + 1), 1'b1,
              (i == 0) ? 2'd3 : 2'((i - 1) % 4), 1'b1);
      tick();
      tick();
      oh = 4'b0001 << (i % 4);
      chk_out($sformatf("rr%0d", i), oh, 4'(i % 4 + 1), 1'b1,
              2'(i % 4), 1'b1);
    end
    req = '0;
    tick();
    tick();
    chk_out("idle_b", 4'b0000, 4'h1, 1'b1, 2'd0, 1'b0);

    clr = 1'b1;
    req = 4'b0001;
    tick();
    chk_out("clr_prio", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);
    clr = 1'b0;
    tick();
    chk_out("after_clr", 4'b0001, 4'h1, 1'b1, 2'd0, 1'b1);
    req = '0;
    clr = 1'b1;
    tick();
    chk_out("clr_hold", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b1);
    clr = 1'b0;
    tick();
    chk_out("hold_kept", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);

    req = 4'b0100;
    tick();
    chk_out("g2", 4'b0100, 4'h3, 1'b1, 2'd2, 1'b1);
    rst = 1'b1;
    req = 4'b1010;
    tick();
    chk_out("rst_mid", 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("post_rst", 4'b0010, 4'h2, 1'b1, 2'd1, 1'b1);
    req = '0;
    clr = 1'b1;
    tick();
    chk_out("clr_owner", 4'b0000, 4'h0, 1'b0, 2'd1, 1'b1);
    clr = 1'b0;
    tick();
    chk_out("end_idle", 4'b0000, 4'h0, 1'b0, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipo_share_arbiter.md
Name: pipo_share_arbiter

Overview:
- Round-robin arbiter that shares one W-bit parallel-in/parallel-out holding register among N_REQ requesters.
- Each grant loads the winner's data word into the register, records the owner, and pulses a one-cycle grant.
- After each load, the register is held stable for HOLD_CYCLES cycles before the next arbitration.
- Sits between several producer blocks and a single downstream consumer of the registered word.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 4, data/register width in bits.
- HOLD_CYCLES, 2, cycles the register is frozen after each load (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level; bit i = requester i.
- req_data  input  N_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of the shared register.
- gnt  output  N_REQ  registered one-hot grant pulse.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  register holds a granted word.
- q_owner  output  clog2(N_REQ)  index of the requester whose data is in q.
- busy  output  1  hold window active; no arbitration.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, ptr=0, cnt=0.
  - q=0, q_valid=0, q_owner=0, gnt=0, busy=0.
  - rst overrides everything, including mid-HOLD; an aborted hold issues no further grant.
- State machine: two states, IDLE and HOLD. busy = (state==HOLD), decoded from the state register.
- IDLE, no request (req==0): remain in IDLE; gnt=0; q, q_valid and q_owner unchanged.
- IDLE, any req bit set and clr=0, at the posedge:
  - winner = first set bit of req searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - q <= winner's data slice; q_owner <= winner; q_valid <= 1.
  - gnt <= one-hot(winner) for exactly one cycle.
  - ptr <= (winner+1) mod N_REQ; wrap from N_REQ-1 to 0.
  - cnt <= HOLD_CYCLES-1; state <= HOLD.
- Load latency: data presented in the cycle req is sampled appears on q in the following cycle, the same cycle gnt is high.
- HOLD:
  - gnt=0; q is frozen; req is ignored.
  - If cnt==0, state <= IDLE; otherwise cnt <= cnt-1.
  - busy is therefore high for exactly HOLD_CYCLES cycles.
- Grant throughput: with continuous requests, grants are spaced exactly HOLD_CYCLES+1 cycles apart.
- Requester handshake:
  - A requester must deassert req in the cycle it sees its gnt bit, unless it wants another slot.
  - A held req is re-arbitrated fairly and loses priority to the others via the ptr rotation.
- clr=1, not in reset:
  - q <= 0, q_valid <= 0; q_owner unchanged.
  - clr has priority over a same-cycle IDLE arbitration: no grant, ptr unchanged, state stays IDLE.
  - clr during HOLD clears q but does not shorten the hold window.
- Fairness: no requester waits more than N_REQ-1 grants while its req is held.
- Arithmetic:
  - ptr and q_owner are clog2(N_REQ) bits wide.
  - Wrap uses explicit compare-to-(N_REQ-1); no reliance on power-of-two overflow.

Test Plan (N_REQ=4, WIDTH=4, HOLD_CYCLES=2):
- Reset check: after reset, q=0, q_valid=0, gnt=0, busy=0. Then req=4'b0100 with data[2]=4'hA for 1 cycle -> next cycle gnt=4'b0100, q=4'hA, q_owner=2, q_valid=1; busy=1 for 2 cycles.
- Round-robin: req=4'b1111 held; data slices 1,2,3,4 for requesters 0..3 -> grants to 0,1,2,3,0 at cycles t, t+3, t+6, t+9, t+12; q follows 1,2,3,4,1.
- Hold freeze: during busy, change req_data and raise a new req -> q, q_owner unchanged and gnt=0 until busy falls.
- Wrap with pointer: last grant to 3 (ptr=0), then req=4'b1010 -> grant to 1, then to 3.
- clr priority: in IDLE assert clr and req=4'b0001 in the same cycle -> q=0, q_valid=0, gnt=0, ptr unchanged. Next cycle, with clr=0, requester 0 is granted.
- Reset mid-HOLD: assert rst one cycle after a grant -> all outputs zero next cycle. A pending req is next granted starting from requester 0.
